// File: rtl/steer_quad_decoder.sv
// Quadrature steering decoder: synchronises and glitch-filters SteerA/SteerB, decodes
// Gray-code steps into a wrapping position and a saturating read-and-clear delta.
//
// state   | meaning
// S_INIT  | waiting for the filtered phases to settle, then capturing the baseline pair
// S_TRACK | decoding every change of the filtered pair against the previous pair
module steer_quad_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Ce,
  input  logic             SteerA_I,
  input  logic             SteerB_I,
  input  logic             Rd_I,
  input  logic             ErrClr_I,
  output logic [CNT_W-1:0] Pos_O,
  output logic [CNT_W-1:0] Delta_O,
  output logic             Step_O,
  output logic             Dir_O,
  output logic             Err_O,
  output logic             Valid_O
);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  localparam logic [3:0]       FL_LAST = 4'(FILTER_LEN - 1);
  localparam logic [4:0]       WU_DONE = 5'(FILTER_LEN + 2);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       ref_q, ref_d;
  logic [3:0]       fcnt_a_q, fcnt_a_d, fcnt_b_q, fcnt_b_d;
  logic [4:0]       wu_q, wu_d;
  logic [CNT_W-1:0] pos_q, pos_d, acc_q, acc_d, acc_nx, delta_q, delta_d;
  logic             step_q, step_d, dir_q, dir_d, err_q, err_d, valid_q, valid_d;
  logic             inc, dec;
  logic [1:0]       idx_diff;

  // Returns {filtered bit, counter} after one Ce sample.
  function automatic logic [4:0] filt_next(input logic s, input logic f, input logic [3:0] c);
    if (s == f) return {f, 4'd0};
    if (c == FL_LAST) return {s, 4'd0};
    return {f, c + 4'd1};
  endfunction

  // Position of a {A,B} pair along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  always_comb begin
    filt_d   = filt_q;
    fcnt_a_d = fcnt_a_q;
    fcnt_b_d = fcnt_b_q;
    if (Ce) begin
      {filt_d[1], fcnt_a_d} = filt_next(sync2_q[1], filt_q[1], fcnt_a_q);
      {filt_d[0], fcnt_b_d} = filt_next(sync2_q[0], filt_q[0], fcnt_b_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    valid_d  = valid_q;
    wu_d     = wu_q;
    inc      = 1'b0;
    dec      = 1'b0;
    err_d    = err_q & ~ErrClr_I;
    idx_diff = gray_idx(filt_q) - gray_idx(ref_q);
    case (state_q)
      S_INIT: begin
        // Wait for the sync pipeline plus one full filter window before trusting the pair.
        if (Ce && wu_q != WU_DONE) wu_d = wu_q + 5'd1;
        if (Ce && wu_q == WU_DONE && sync2_q == filt_q) begin
          ref_d   = filt_q;
          valid_d = 1'b1;
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        if (filt_q != ref_q) begin
          ref_d = filt_q;
          case (idx_diff)
            2'd1:    inc   = 1'b1;
            2'd3:    dec   = 1'b1;
            default: err_d = 1'b1;
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    pos_d  = pos_q;
    acc_nx = acc_q;
    if (inc) begin
      pos_d = pos_q + ONE;
      if (acc_q != ACC_MAX) acc_nx = acc_q + ONE;
    end else if (dec) begin
      pos_d = pos_q - ONE;
      if (acc_q != ACC_MIN) acc_nx = acc_q - ONE;
    end
    acc_d   = Rd_I ? '0 : acc_nx;
    delta_d = Rd_I ? acc_nx : delta_q;
    step_d  = inc | dec;
    dir_d   = inc ? 1'b1 : (dec ? 1'b0 : dir_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_INIT;
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      ref_q    <= '0;
      fcnt_a_q <= '0;
      fcnt_b_q <= '0;
      wu_q     <= '0;
      pos_q    <= '0;
      acc_q    <= '0;
      delta_q  <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= {SteerA_I, SteerB_I};
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      ref_q    <= ref_d;
      fcnt_a_q <= fcnt_a_d;
      fcnt_b_q <= fcnt_b_d;
      wu_q     <= wu_d;
      pos_q    <= pos_d;
      acc_q    <= acc_d;
      delta_q  <= delta_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign Pos_O   = pos_q;
  assign Delta_O = delta_q;
  assign Step_O  = step_q;
  assign Dir_O   = dir_q;
  assign Err_O   = err_q;
  assign Valid_O = valid_q;

endmodule

// File: tb/tb_steer_quad_decoder.sv
// Self-checking bench for steer_quad_decoder: vector table, hand-written corner
// sequences and randomized phase moves checked against a step-level model.
module tb_steer_quad_decoder;

  localparam int FL  = 4;
  localparam int CW  = 8;
  localparam int MSK = (1 << CW) - 1;

  logic          Clk = 1'b0, Reset_n = 1'b0, Ce = 1'b1;
  logic          SteerA_I = 1'b0, SteerB_I = 1'b0, Rd_I = 1'b0, ErrClr_I = 1'b0;
  logic [CW-1:0] Pos_O, Delta_O;
  logic          Step_O, Dir_O, Err_O, Valid_O;

  int n_tests = 0, n_fail = 0, step_cnt = 0;
  int m_pos = 0, m_acc = 0, m_err = 0, m_dir = 0, idx = 0;

  typedef struct {
    int mv; int hold; bit rd; bit clr;
    int exp_pos; int exp_steps; bit exp_dir; bit exp_err; int exp_delta;
  } vec_t;
  vec_t tbl[9];

  steer_quad_decoder #(.FILTER_LEN(FL), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Ce(Ce), .SteerA_I(SteerA_I), .SteerB_I(SteerB_I),
    .Rd_I(Rd_I), .ErrClr_I(ErrClr_I), .Pos_O(Pos_O), .Delta_O(Delta_O), .Step_O(Step_O),
    .Dir_O(Dir_O), .Err_O(Err_O), .Valid_O(Valid_O)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Reset_n && Step_O) step_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [1:0] gray(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // d: +1/-1 legal step, 2 = both phases flip, 0 = no change
  task automatic model_move(input int d);
    idx = (idx + d) & 3;
    {SteerA_I, SteerB_I} = gray(idx);
    if (d == 1 || d == -1) begin
      m_pos = (m_pos + d) & MSK;
      if (d == 1 && m_acc < (1 << (CW - 1)) - 1) m_acc++;
      if (d == -1 && m_acc > -(1 << (CW - 1))) m_acc--;
      m_dir = (d == 1) ? 1 : 0;
    end else if (d == 2) begin
      m_err = 1;
    end
  endtask

  task automatic do_move(input int d, input int h);
    int s0;
    s0 = step_cnt;
    model_move(d);
    hold(h);
    chk("pos", int'(Pos_O), m_pos);
    chk("steps", step_cnt - s0, (d == 1 || d == -1) ? 1 : 0);
    chk("dir", int'(Dir_O), m_dir);
    chk("err", int'(Err_O), m_err);
  endtask

  task automatic do_rd();
    Rd_I = 1'b1;
    tick();
    Rd_I = 1'b0;
    chk("delta", int'(Delta_O), m_acc & MSK);
    m_acc = 0;
  endtask

  task automatic do_clr();
    ErrClr_I = 1'b1;
    tick();
    ErrClr_I = 1'b0;
    m_err = 0;
    chk("err_clr", int'(Err_O), 0);
  endtask

  task automatic do_reset(input int start_idx);
    Reset_n = 1'b0;
    idx = start_idx;
    {SteerA_I, SteerB_I} = gray(idx);
    hold(2);
    Reset_n = 1'b1;
    hold(10);
    m_pos = 0; m_acc = 0; m_err = 0; m_dir = 0;
    chk("valid_after_reset", int'(Valid_O), 1);
  endtask

  initial begin
    int s0, r, ph, len;
    tbl[0] = '{ 1, 10, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 0};
    tbl[1] = '{ 1, 10, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 0};
    tbl[2] = '{ 1, 10, 1'b0, 1'b0, 3, 1, 1'b1, 1'b0, 0};
    tbl[3] = '{ 1, 10, 1'b1, 1'b0, 4, 1, 1'b1, 1'b0, 4};
    tbl[4] = '{ 0,  4, 1'b1, 1'b0, 4, 0, 1'b1, 1'b0, 0};
    tbl[5] = '{-1, 10, 1'b0, 1'b0, 3, 1, 1'b0, 1'b0, 0};
    tbl[6] = '{ 2, 10, 1'b0, 1'b1, 3, 0, 1'b0, 1'b1, 0};
    tbl[7] = '{-1, 10, 1'b1, 1'b0, 2, 1, 1'b0, 1'b0, 254};
    tbl[8] = '{ 2, 10, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1, 0};

    // Reset state, then baseline capture with phases at 11
    SteerA_I = 1'b1; SteerB_I = 1'b1; idx = 2;
    #1;
    chk("rst_pos", int'(Pos_O), 0);
    chk("rst_delta", int'(Delta_O), 0);
    chk("rst_step", int'(Step_O), 0);
    chk("rst_dir", int'(Dir_O), 0);
    chk("rst_err", int'(Err_O), 0);
    chk("rst_valid", int'(Valid_O), 0);
    hold(2);
    Reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("valid_edge%0d", k), int'(Valid_O), (k >= 6) ? 1 : 0);
    end
    chk("init_pos", int'(Pos_O), 0);
    chk("init_steps", step_cnt, 0);
    chk("init_err", int'(Err_O), 0);

    // Vector table from a 00 baseline
    do_reset(0);
    for (int i = 0; i < 9; i++) begin
      s0 = step_cnt;
      model_move(tbl[i].mv);
      hold(tbl[i].hold);
      chk($sformatf("tbl%0d_pos", i), int'(Pos_O), tbl[i].exp_pos);
      chk($sformatf("tbl%0d_steps", i), step_cnt - s0, tbl[i].exp_steps);
      chk($sformatf("tbl%0d_dir", i), int'(Dir_O), int'(tbl[i].exp_dir));
      chk($sformatf("tbl%0d_err", i), int'(Err_O), int'(tbl[i].exp_err));
      if (tbl[i].rd) begin
        Rd_I = 1'b1; tick(); Rd_I = 1'b0;
        chk($sformatf("tbl%0d_delta", i), int'(Delta_O), tbl[i].exp_delta);
        m_acc = 0;
      end
      if (tbl[i].clr) begin
        ErrClr_I = 1'b1; tick(); ErrClr_I = 1'b0;
        chk($sformatf("tbl%0d_errclr", i), int'(Err_O), 0);
        m_err = 0;
      end
    end

    // ErrClr_I in the same cycle as a new illegal transition: error stays set
    model_move(2);
    hold(6);
    ErrClr_I = 1'b1;
    tick();
    ErrClr_I = 1'b0;
    chk("errclr_vs_illegal", int'(Err_O), 1);
    hold(4);
    do_clr();

    // Glitches on SteerA: 3 samples rejected, 4 samples accepted
    s0 = step_cnt;
    SteerA_I = ~SteerA_I; hold(3); SteerA_I = ~SteerA_I; hold(10);
    chk("glitch3_steps", step_cnt - s0, 0);
    chk("glitch3_pos", int'(Pos_O), m_pos);
    model_move(-1); hold(4); model_move(1); hold(4);
    chk("glitch4_steps", step_cnt - s0, 1);
    chk("glitch4_pos", int'(Pos_O), (m_pos - 1) & MSK);
    hold(10);
    chk("glitch4_return_steps", step_cnt - s0, 2);
    chk("glitch4_return_pos", int'(Pos_O), m_pos);

    // Rd_I on the same cycle as a +1 step with accumulator 2
    do_rd();
    do_move(1, 10);
    do_move(1, 10);
    model_move(1);
    hold(6);
    Rd_I = 1'b1;
    tick();
    Rd_I = 1'b0;
    chk("rd_same_step", int'(Step_O), 1);
    chk("rd_same_delta", int'(Delta_O), 3);
    m_acc = 0;
    hold(4);
    chk("rd_same_pos", int'(Pos_O), m_pos);
    do_rd();

    // 130 reverse steps: position wraps, delta saturates
    do_reset(0);
    s0 = step_cnt;
    for (int i = 0; i < 130; i++) begin
      model_move(-1);
      hold(10);
    end
    chk("rev130_steps", step_cnt - s0, 130);
    chk("rev130_pos", int'(Pos_O), 8'h7E);
    Rd_I = 1'b1; tick(); Rd_I = 1'b0;
    chk("rev130_delta", int'(Delta_O), 8'h80);
    m_acc = 0;
    do_rd();

    // Randomized moves against the step-level model
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) do_move(1, $urandom_range(10, 14));
      else if (r <= 6) do_move(-1, $urandom_range(10, 14));
      else if (r == 7) do_move(2, $urandom_range(10, 14));
      else begin
        s0 = step_cnt;
        ph = $urandom_range(0, 1);
        len = $urandom_range(1, FL - 1);
        if (ph == 1) SteerA_I = ~SteerA_I; else SteerB_I = ~SteerB_I;
        hold(len);
        if (ph == 1) SteerA_I = ~SteerA_I; else SteerB_I = ~SteerB_I;
        hold(10);
        chk("rnd_glitch_steps", step_cnt - s0, 0);
        chk("rnd_glitch_pos", int'(Pos_O), m_pos);
      end
      if ($urandom_range(0, 2) == 0) do_rd();
      if (m_err == 1 && $urandom_range(0, 3) == 0) do_clr();
    end

    // Ce low: filter holds, no step until sampling resumes
    Ce = 1'b0;
    s0 = step_cnt;
    model_move(1);
    hold(20);
    chk("ce_low_steps", step_cnt - s0, 0);
    chk("ce_low_pos", int'(Pos_O), (m_pos - 1) & MSK);
    Ce = 1'b1;
    hold(10);
    chk("ce_high_steps", step_cnt - s0, 1);
    chk("ce_high_pos", int'(Pos_O), m_pos);

    // Reset pulsed mid-step: everything returns to reset values at once
    do_rd();
    do_move(1, 10);
    model_move(1);
    hold(7);
    chk("pre_rst_step", int'(Step_O), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_pos", int'(Pos_O), 0);
    chk("mid_rst_delta", int'(Delta_O), 0);
    chk("mid_rst_step", int'(Step_O), 0);
    chk("mid_rst_dir", int'(Dir_O), 0);
    chk("mid_rst_err", int'(Err_O), 0);
    chk("mid_rst_valid", int'(Valid_O), 0);
    hold(2);
    s0 = step_cnt;
    Reset_n = 1'b1;
    hold(12);
    chk("post_rst_valid", int'(Valid_O), 1);
    chk("post_rst_steps", step_cnt - s0, 0);
    chk("post_rst_pos", int'(Pos_O), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
